// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the emulated 4x4 matrix keypad:
//   - state_t       : sequencer states of the key-press replay FSM
//   - LFSR_W/TAPS   : width and Fibonacci tap mask of the contact-bounce LFSR
//                     (x^8 + x^6 + x^5 + x^4 + 1)
//   - key_row/col   : key-code decode, shared with the column comparator so the
//                     key encoding lives in exactly one place
//   - col_onehot    : column index to one-hot column sense pattern
// -----------------------------------------------------------------------------
package keypad_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESS_BOUNCE,
        ST_HOLD,
        ST_RELEASE_BOUNCE,
        ST_GAP
    } state_t;

    localparam int LFSR_W = 8;

    // Feedback taps at bits 7,5,4,3 of a left-shifting register.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

    function automatic logic [1:0] key_row(input logic [3:0] key);
        return key[3:2];
    endfunction

    function automatic logic [1:0] key_col(input logic [3:0] key);
        return key[1:0];
    endfunction

    function automatic logic [3:0] col_onehot(input logic [1:0] c);
        return 4'b0001 << c;
    endfunction

endpackage

// File: rtl/keypad_emulator_if.sv
// -----------------------------------------------------------------------------
// keypad_emulator_if
// Bundles the keypad matrix lines and the key-press command channel.
//   fil        : row drive from the scanner (active-high, normally one-hot)
//   col        : column sense back to the comparator (active-high)
//   cmd_valid  : command present
//   cmd_key    : key code, row = [3:2], column = [1:0]
//   cmd_hold   : stable-closed duration in clk cycles (0 means 1)
//   cmd_ready  : emulator idle, command accepted on valid & ready
//   busy       : command in progress
//   done       : one-cycle pulse on the last gap cycle
// master = scanner + commander side, slave = keypad emulator.
// -----------------------------------------------------------------------------
interface keypad_emulator_if #(
    parameter int HOLD_W = 16
);
    logic [3:0]        fil;
    logic [3:0]        col;
    logic              cmd_valid;
    logic [3:0]        cmd_key;
    logic [HOLD_W-1:0] cmd_hold;
    logic              cmd_ready;
    logic              busy;
    logic              done;

    modport master (
        output fil,
        output cmd_valid,
        output cmd_key,
        output cmd_hold,
        input  col,
        input  cmd_ready,
        input  busy,
        input  done
    );

    modport slave (
        input  fil,
        input  cmd_valid,
        input  cmd_key,
        input  cmd_hold,
        output col,
        output cmd_ready,
        output busy,
        output done
    );
endinterface

// File: rtl/keypad_emulator_bounce_lfsr.sv
// -----------------------------------------------------------------------------
// bounce_lfsr
// 8-bit Fibonacci LFSR supplying pseudo-random contact chatter.
//   clk     : system clock
//   rst     : synchronous active-high reset, loads SEED
//   en      : advance one step this cycle
//   bit_out : current LFSR bit 0
// The sequence is only reseeded by reset, so successive bounce windows differ
// while the whole run stays deterministic from reset.
// -----------------------------------------------------------------------------
module bounce_lfsr
    import keypad_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic bit_out
);

    logic [LFSR_W-1:0] lfsr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else if (en) begin
            lfsr_q <= {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    assign bit_out = lfsr_q[0];

endmodule

// File: rtl/keypad_emulator.sv
// -----------------------------------------------------------------------------
// keypad_emulator
// Far end of a row-scan / column-sense 4x4 keypad. Replays one key-press
// command at a time: press chatter, solid hold, release chatter, open gap.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : keypad_emulator_if.slave (matrix lines + command channel)
// Parameters:
//   BOUNCE_CYCLES : chatter length on press and on release (>=1)
//   GAP_CYCLES    : open time after release before next command (>=1)
//   HOLD_W        : width of the hold-time field
//   LFSR_SEED     : non-zero reset value of the bounce LFSR
//
// state             | meaning
// ------------------+----------------------------------------------------
// ST_IDLE           | contact open, cmd_ready high, waiting for a command
// ST_PRESS_BOUNCE   | contact follows LFSR bit 0 for BOUNCE_CYCLES
// ST_HOLD           | contact closed for the latched hold count
// ST_RELEASE_BOUNCE | contact follows LFSR bit 0 for BOUNCE_CYCLES
// ST_GAP            | contact open for GAP_CYCLES, done on the last cycle
// -----------------------------------------------------------------------------
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int                BOUNCE_CYCLES = 16,
    parameter int                GAP_CYCLES    = 64,
    parameter int                HOLD_W        = 16,
    parameter logic [LFSR_W-1:0] LFSR_SEED     = 8'hA5
) (
    input  logic clk,
    input  logic rst,
    keypad_emulator_if.slave bus
);

    localparam int BOUNCE_W = $clog2(BOUNCE_CYCLES + 1);
    localparam int GAP_W    = $clog2(GAP_CYCLES + 1);

    localparam logic [BOUNCE_W-1:0] BOUNCE_LOAD = BOUNCE_W'(BOUNCE_CYCLES);
    localparam logic [GAP_W-1:0]    GAP_LOAD    = GAP_W'(GAP_CYCLES);
    localparam logic [BOUNCE_W-1:0] BOUNCE_ONE  = BOUNCE_W'(1);
    localparam logic [GAP_W-1:0]    GAP_ONE     = GAP_W'(1);
    localparam logic [HOLD_W-1:0]   HOLD_ONE    = HOLD_W'(1);

    state_t              state_q, state_d;
    logic [BOUNCE_W-1:0] bounce_cnt_q, bounce_cnt_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [3:0]          key_q, key_d;

    logic lfsr_en;
    logic lfsr_bit;
    logic contact;
    logic cmd_ready_o;
    logic busy_o;
    logic done_o;

    bounce_lfsr #(
        .SEED (LFSR_SEED)
    ) u_bounce_lfsr (
        .clk     (clk),
        .rst     (rst),
        .en      (lfsr_en),
        .bit_out (lfsr_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            bounce_cnt_q <= '0;
            gap_cnt_q    <= '0;
            hold_cnt_q   <= '0;
            key_q        <= '0;
        end else begin
            state_q      <= state_d;
            bounce_cnt_q <= bounce_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            key_q        <= key_d;
        end
    end

    // Each timed phase loads its down-counter on entry and leaves when the
    // counter reads 1, so a load of N gives exactly N cycles in the phase.
    always_comb begin
        state_d      = state_q;
        bounce_cnt_d = bounce_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        key_d        = key_q;
        lfsr_en      = 1'b0;
        contact      = 1'b0;
        cmd_ready_o  = 1'b0;
        busy_o       = 1'b1;
        done_o       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cmd_ready_o = 1'b1;
                busy_o      = 1'b0;
                if (bus.cmd_valid) begin
                    state_d      = ST_PRESS_BOUNCE;
                    bounce_cnt_d = BOUNCE_LOAD;
                    hold_cnt_d   = (bus.cmd_hold == '0) ? HOLD_ONE : bus.cmd_hold;
                    key_d        = bus.cmd_key;
                end
            end

            ST_PRESS_BOUNCE: begin
                lfsr_en = 1'b1;
                contact = lfsr_bit;
                if (bounce_cnt_q == BOUNCE_ONE) begin
                    state_d = ST_HOLD;
                end else begin
                    bounce_cnt_d = bounce_cnt_q - BOUNCE_ONE;
                end
            end

            ST_HOLD: begin
                contact = 1'b1;
                if (hold_cnt_q == HOLD_ONE) begin
                    state_d      = ST_RELEASE_BOUNCE;
                    bounce_cnt_d = BOUNCE_LOAD;
                end else begin
                    hold_cnt_d = hold_cnt_q - HOLD_ONE;
                end
            end

            ST_RELEASE_BOUNCE: begin
                lfsr_en = 1'b1;
                contact = lfsr_bit;
                if (bounce_cnt_q == BOUNCE_ONE) begin
                    state_d   = ST_GAP;
                    gap_cnt_d = GAP_LOAD;
                end else begin
                    bounce_cnt_d = bounce_cnt_q - BOUNCE_ONE;
                end
            end

            ST_GAP: begin
                if (gap_cnt_q == GAP_ONE) begin
                    done_o  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.cmd_ready = cmd_ready_o;
    assign bus.busy      = busy_o;
    assign bus.done      = done_o;

    // Passive switch: contact depends only on registered state, while the row
    // to column path stays combinational so col tracks fil with no latency.
    assign bus.col = (contact && bus.fil[key_row(key_q)]) ? col_onehot(key_col(key_q))
                                                          : 4'b0000;

endmodule

// File: doc/keypad_emulator.md
# keypad_emulator

Emulated 4x4 matrix keypad: the far end of the row-scan / column-sense keypad interface used by the calculator. It watches the row lines driven by the row scanner and returns column lines as a physical keypad would, replaying queued key-press commands with configurable contact bounce. It is used on-board for hardware-in-loop self-test of the scanner, comparator and calculator datapath without a physical keypad.

## Interface
- BOUNCE_CYCLES, 16: clk cycles of contact chatter on press and on release (>=1).
- GAP_CYCLES, 64: clk cycles contact stays open after release before the next command is accepted (>=1).
- HOLD_W, 16: width of the hold-time field.
- LFSR_SEED, 8'hA5: reset/seed value of the bounce LFSR (must be non-zero).
- clk  in  1  system clock; one clock domain. Reset is synchronous and active-high.
- rst  in  1  synchronous, active-high reset.
- fil  in  4  row drive from the scanner, active-high; normally one-hot.
- col  out  4  column sense to the comparator, active-high.
- cmd_valid  in  1  command present.
- cmd_key  in  4  key code; row = cmd_key[3:2], column = cmd_key[1:0].
- cmd_hold  in  HOLD_W  stable-closed duration in clk cycles; 0 treated as 1.
- cmd_ready  out  1  high when idle; a command is accepted on a clk edge with cmd_valid & cmd_ready.
- busy  out  1  high from acceptance until done.
- done  out  1  one-cycle pulse at end of the gap phase.

## Operation
- States: IDLE, PRESS_BOUNCE, HOLD, RELEASE_BOUNCE, GAP.
- IDLE: contact open; cmd_ready=1. On accept: latch key and hold (0 -> 1), load counter, go PRESS_BOUNCE.
- PRESS_BOUNCE: BOUNCE_CYCLES cycles; contact = lfsr[0], LFSR advances every cycle (x^8+x^6+x^5+x^4+1, Fibonacci). Then HOLD.
- HOLD: contact = 1 for latched hold cycles. Then RELEASE_BOUNCE.
- RELEASE_BOUNCE: BOUNCE_CYCLES cycles, contact = lfsr[0]. Then GAP.
- GAP: contact = 0 for GAP_CYCLES cycles; done pulses on the last GAP cycle; next state IDLE.
- LFSR free-runs only in the bounce states; it is not reseeded between commands, so successive presses bounce differently. This is deterministic from reset.
- col = (contact & fil[key_row]) ? one-hot(key_col) : 0. This path is combinational from fil to model a passive switch; contact is registered.
- fil all zero -> col = 0. fil with several bits set -> col is driven if the key's row bit is among them. Emulator never drives more than one col bit.
- cmd_valid while busy: ignored. No queueing; the commander holds cmd_valid until cmd_ready.
- Hold counter is HOLD_W bits. Bounce and gap counters are sized with $clog2 of their parameters. No wrap: counters load a value and count down to 1.

## Timing
- Reset values: state IDLE, contact 0, col 0, busy 0, done 0, cmd_ready 1 (derived from state), lfsr = LFSR_SEED.
- Reset mid-operation: on the rst edge, state goes to IDLE and contact goes to 0. The command is abandoned and no done is issued.
- Accept at edge T. PRESS_BOUNCE occupies cycles T+1..T+B. HOLD occupies T+B+1..T+B+H. RELEASE_BOUNCE occupies the next B cycles. GAP occupies the next G cycles, with done high in the last one. cmd_ready is high in cycle T+2B+H+G+1.
- Total command occupancy: 2*BOUNCE_CYCLES + hold + GAP_CYCLES cycles. busy is high across exactly that window.
- col changes in the same cycle fil changes, with zero-cycle latency from fil.
- Accept and done never coincide. A new accept is possible in the first IDLE cycle after done.

## Structure
- Package keypad_pkg holds:
  - the state enum;
  - the LFSR tap mask and width constant;
  - key_row/key_col helper functions, shared with the column comparator so key encoding is defined once.
- Sub-module bounce_lfsr: 8-bit LFSR with enable and seed-on-reset; output bit 0.
- Top holds the FSM, counters, key latch and column mux. Target size is roughly 150-250 lines.

## Test plan
- Reset then key 4'h6 (row 1, col 2), hold 100, B=16, G=64: cmd_ready low for 196 cycles. With fil=4'b0010, col=4'b0100 throughout HOLD; col=0 for fil=4'b0001/0100/1000. done pulses once at cycle 196.
- Bounce check: during PRESS_BOUNCE, contact follows the LFSR sequence from seed 8'hA5 bit-exactly. Contact is solid 1 for all of HOLD and solid 0 for all of GAP.
- cmd_hold=0, key 4'hF: HOLD lasts exactly 1 cycle; col=4'b1000 when fil=4'b1000.
- cmd_valid held high with a new key during busy: no acceptance until the IDLE cycle after done; second key is then replayed with correct row/col.
- rst asserted in mid-HOLD: col=0 and busy=0 the next cycle, no done, cmd_ready=1. LFSR restarts from seed on the next command.
- Drive fil from the real row scanner and run keys 0..F in sequence: the comparator reports each key code exactly once after debounce.
